// File: rtl/pacman_move_ctrl_if.sv
// Maze wall-query handshake between the movement scheduler (master) and the tile map (slave).
// Request is held with a stable tile until a one-cycle ack; hit is meaningful only alongside ack.
interface pacman_move_ctrl_if;
  logic       wall_req;
  logic [6:0] wall_tx;
  logic [6:0] wall_ty;
  logic       wall_ack;
  logic       wall_hit;

  modport master (output wall_req, wall_tx, wall_ty, input wall_ack, wall_hit);
  modport slave  (input wall_req, wall_tx, wall_ty, output wall_ack, wall_hit);
endinterface

// File: rtl/pacman_move_ctrl.sv
// Pac-Man movement scheduler: latches keyboard direction, wall-checks on tile alignment, pulses steps.
// Latency from divider wrap: aligned = query cycle + ack delay + 1, unaligned = 1; missing ack times out as a wall.
module pacman_move_ctrl #(
  parameter int TILE_LOG2 = 3,
  parameter int STEP_DIV  = 2,
  parameter int TIMEOUT   = 7
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic [7:0]         keycode,
  input  logic [9:0]         pos_x,
  input  logic [9:0]         pos_y,
  pacman_move_ctrl_if.master wall,
  output logic [1:0]         dir,
  output logic               moving,
  output logic               move_en,
  output logic [9:0]         motion_x,
  output logic [9:0]         motion_y,
  output logic               pend_valid
);

  typedef enum logic [1:0] {S_WAIT, S_Q_PEND, S_Q_CUR, S_STEP} state_t;

  localparam logic [3:0] DIV_LAST = 4'(STEP_DIV - 1);
  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [3:0] div_q, tmo_q;
  logic [1:0] pend_dir, q_dir_q, cand_dir, key_dir;
  logic [6:0] wall_tx_q, wall_ty_q, tile_x, tile_y, nb_x, nb_y;
  logic       key_vld, aligned, q_done, q_hit, q_enter, in_query, commit;

  assign aligned  = (pos_x[TILE_LOG2-1:0] == '0) && (pos_y[TILE_LOG2-1:0] == '0);
  assign tile_x   = 7'(pos_x >> TILE_LOG2);
  assign tile_y   = 7'(pos_y >> TILE_LOG2);
  assign in_query = (state == S_Q_PEND) || (state == S_Q_CUR);

  always_comb begin
    key_vld = 1'b0;
    key_dir = 2'd0;
    case (keycode)
      8'h1A: begin key_vld = 1'b1; key_dir = 2'd0; end
      8'h04: begin key_vld = 1'b1; key_dir = 2'd1; end
      8'h16: begin key_vld = 1'b1; key_dir = 2'd2; end
      8'h07: begin key_vld = 1'b1; key_dir = 2'd3; end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    move_en   = 1'b0;
    q_done    = 1'b0;
    q_hit     = 1'b0;
    case (state)
      S_WAIT: begin
        if (div_q == DIV_LAST) begin
          if (!aligned)       state_nxt = S_STEP;
          else if (pend_valid) state_nxt = S_Q_PEND;
          else                state_nxt = S_Q_CUR;
        end
      end
      S_Q_PEND, S_Q_CUR: begin
        // A silent maze is treated as a wall so the sprite never walks blind.
        if (wall.wall_ack) begin
          q_done = 1'b1;
          q_hit  = wall.wall_hit;
        end else if (tmo_q == TMO_LAST) begin
          q_done = 1'b1;
          q_hit  = 1'b1;
        end
        if (q_done) begin
          if (!q_hit)                 state_nxt = S_STEP;
          else if (state == S_Q_PEND) state_nxt = S_Q_CUR;
          else                        state_nxt = S_WAIT;
        end
      end
      S_STEP: begin
        move_en   = 1'b1;
        state_nxt = S_WAIT;
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  // The query target is captured on entry so a key press mid-query cannot move it.
  assign q_enter  = (state_nxt != state) && ((state_nxt == S_Q_PEND) || (state_nxt == S_Q_CUR));
  assign cand_dir = (state_nxt == S_Q_PEND) ? pend_dir : dir;
  assign commit   = (state == S_Q_PEND) && q_done && !q_hit;

  always_comb begin
    nb_x = tile_x;
    nb_y = tile_y;
    case (cand_dir)
      2'd0:    nb_y = tile_y - 7'd1;
      2'd1:    nb_x = tile_x - 7'd1;
      2'd2:    nb_y = tile_y + 7'd1;
      default: nb_x = tile_x + 7'd1;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_WAIT;
      div_q      <= '0;
      tmo_q      <= '0;
      dir        <= 2'd3;
      pend_dir   <= 2'd0;
      pend_valid <= 1'b0;
      q_dir_q    <= 2'd0;
      moving     <= 1'b0;
      wall_tx_q  <= '0;
      wall_ty_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_WAIT)
        div_q <= (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
      tmo_q <= (in_query && state_nxt == state) ? tmo_q + 4'd1 : 4'd0;
      if (q_enter) begin
        wall_tx_q <= nb_x;
        wall_ty_q <= nb_y;
        q_dir_q   <= cand_dir;
      end
      if (commit) dir <= q_dir_q;
      // A key landing with a commit stays pending for the next aligned check.
      if (key_vld) begin
        pend_dir   <= key_dir;
        pend_valid <= 1'b1;
      end else if (commit) begin
        pend_valid <= 1'b0;
      end
      if (state == S_STEP)
        moving <= 1'b1;
      else if (state == S_Q_CUR && q_done && q_hit)
        moving <= 1'b0;
    end
  end

  assign wall.wall_req = in_query;
  assign wall.wall_tx  = wall_tx_q;
  assign wall.wall_ty  = wall_ty_q;

  always_comb begin
    motion_x = '0;
    motion_y = '0;
    if (moving || state == S_STEP) begin
      case (dir)
        2'd0:    motion_y = 10'h3FF;
        2'd1:    motion_x = 10'h3FF;
        2'd2:    motion_y = 10'd1;
        default: motion_x = 10'd1;
      endcase
    end
  end

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Directed bench for pacman_move_ctrl: vector table of single-scenario runs plus timeout,
// unaligned-to-aligned turn and reset-mid-query sequences.
module tb_pacman_move_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset     = 1'b1;
  logic [7:0] keycode   = 8'h00;
  logic [9:0] pos_x     = 10'd320;
  logic [9:0] pos_y     = 10'd240;
  logic [1:0] dir;
  logic       moving, move_en, pend_valid;
  logic [9:0] motion_x, motion_y;

  logic [6:0] wx = 7'd100, wy = 7'd100;
  logic       ack_on = 1'b1, late_ack = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  pacman_move_ctrl_if wif ();

  // Maze model: optional same-cycle ack, one configurable wall tile, row/column 127 always wall.
  assign wif.wall_ack = (wif.wall_req & ack_on) | late_ack;
  assign wif.wall_hit = ((wif.wall_tx == wx) && (wif.wall_ty == wy)) ||
                        (wif.wall_tx == 7'd127) || (wif.wall_ty == 7'd127);

  pacman_move_ctrl #(.TILE_LOG2(3), .STEP_DIV(2), .TIMEOUT(7)) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .wall      (wif.master),
    .dir       (dir),
    .moving    (moving),
    .move_en   (move_en),
    .motion_x  (motion_x),
    .motion_y  (motion_y),
    .pend_valid(pend_valid)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic [9:0] px, py;
    logic [7:0] key;
    logic [6:0] wx, wy;
    logic       qseen;
    logic [6:0] qx, qy;
    int         steps;
    logic [1:0] dir;
    logic       mov;
    logic [9:0] mx, my;
    logic       pend;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    Reset    = 1'b1;
    keycode  = 8'h00;
    late_ack = 1'b0;
    @(negedge frame_clk);
    @(negedge frame_clk);
    Reset = 1'b0;
  endtask

  initial begin
    logic       qseen, got, done;
    logic [6:0] qx, qy;
    int         steps, run;

    // px, py, key, wall, first query, steps in 16 cycles, then final dir/moving/motion/pend
    vt[0] = '{10'd320, 10'd240, 8'h00, 7'd100, 7'd100, 1'b1, 7'd41,  7'd30, 4, 2'd3, 1'b1, 10'd1,   10'd0,   1'b0};
    vt[1] = '{10'd320, 10'd240, 8'h1A, 7'd40,  7'd29,  1'b1, 7'd40,  7'd29, 3, 2'd3, 1'b1, 10'd1,   10'd0,   1'b1};
    vt[2] = '{10'd320, 10'd240, 8'h00, 7'd41,  7'd30,  1'b1, 7'd41,  7'd30, 0, 2'd3, 1'b0, 10'd0,   10'd0,   1'b0};
    vt[3] = '{10'd324, 10'd240, 8'h1A, 7'd100, 7'd100, 1'b0, 7'd0,   7'd0,  5, 2'd3, 1'b1, 10'd1,   10'd0,   1'b1};
    vt[4] = '{10'd320, 10'd240, 8'h04, 7'd100, 7'd100, 1'b1, 7'd39,  7'd30, 4, 2'd1, 1'b1, 10'h3FF, 10'd0,   1'b0};
    vt[5] = '{10'd320, 10'd240, 8'h16, 7'd100, 7'd100, 1'b1, 7'd40,  7'd31, 4, 2'd2, 1'b1, 10'd0,   10'd1,   1'b0};
    vt[6] = '{10'd0,   10'd0,   8'h04, 7'd100, 7'd100, 1'b1, 7'd127, 7'd0,  3, 2'd3, 1'b1, 10'd1,   10'd0,   1'b1};
    vt[7] = '{10'd320, 10'd240, 8'h05, 7'd100, 7'd100, 1'b1, 7'd41,  7'd30, 4, 2'd3, 1'b1, 10'd1,   10'd0,   1'b0};

    // Reset values
    @(negedge frame_clk);
    #1;
    chk("rst dir",        32'(dir), 32'd3);
    chk("rst moving",     32'(moving), 32'd0);
    chk("rst move_en",    32'(move_en), 32'd0);
    chk("rst wall_req",   32'(wif.wall_req), 32'd0);
    chk("rst pend_valid", 32'(pend_valid), 32'd0);
    chk("rst motion",     {12'd0, motion_x, motion_y}, 32'd0);

    for (int v = 0; v < 8; v++) begin
      pos_x  = vt[v].px;
      pos_y  = vt[v].py;
      wx     = vt[v].wx;
      wy     = vt[v].wy;
      ack_on = 1'b1;
      do_reset();
      keycode = vt[v].key;
      qseen = 1'b0; qx = '0; qy = '0; steps = 0;
      for (int c = 0; c < 16; c++) begin
        if (c == 1) keycode = 8'h00;
        if (wif.wall_req && !qseen) begin
          qseen = 1'b1;
          qx    = wif.wall_tx;
          qy    = wif.wall_ty;
        end
        if (move_en) steps++;
        @(negedge frame_clk);
      end
      chk($sformatf("v%0d query", v), {17'd0, qseen, qx, qy}, {17'd0, vt[v].qseen, vt[v].qx, vt[v].qy});
      chk($sformatf("v%0d steps", v), 32'(steps), 32'(vt[v].steps));
      chk($sformatf("v%0d dir", v), 32'(dir), 32'(vt[v].dir));
      chk($sformatf("v%0d moving", v), 32'(moving), 32'(vt[v].mov));
      chk($sformatf("v%0d motion_x", v), 32'(motion_x), 32'(vt[v].mx));
      chk($sformatf("v%0d motion_y", v), 32'(motion_y), 32'(vt[v].my));
      chk($sformatf("v%0d pend_valid", v), 32'(pend_valid), 32'(vt[v].pend));
    end

    // Silent maze: request held exactly TIMEOUT cycles, then blocked
    pos_x = 10'd320; pos_y = 10'd240; wx = 7'd100; wy = 7'd100; ack_on = 1'b0;
    do_reset();
    run = 0; done = 1'b0; steps = 0;
    for (int c = 0; c < 20; c++) begin
      if (wif.wall_req && !done) run++;
      if (!wif.wall_req && run > 0) done = 1'b1;
      if (move_en) steps++;
      @(negedge frame_clk);
    end
    chk("timeout req cycles", 32'(run), 32'd7);
    chk("timeout move_en", 32'(steps), 32'd0);
    chk("timeout moving", 32'(moving), 32'd0);

    // Unaligned key press keeps direction; turn happens at the next tile boundary
    pos_x = 10'd324; pos_y = 10'd240; ack_on = 1'b1;
    do_reset();
    keycode = 8'h1A;
    qseen = 1'b0; got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      if (c == 1) keycode = 8'h00;
      if (wif.wall_req) qseen = 1'b1;
      if (move_en) got = 1'b1;
      else @(negedge frame_clk);
    end
    keycode = 8'h00;
    chk("unaligned step seen", 32'(got), 32'd1);
    chk("unaligned no query", 32'(qseen), 32'd0);
    chk("unaligned dir", 32'(dir), 32'd3);
    chk("unaligned pend", 32'(pend_valid), 32'd1);
    chk("unaligned motion_x", 32'(motion_x), 32'd1);
    @(negedge frame_clk);
    pos_x = 10'd328;
    qseen = 1'b0; qx = '0; qy = '0; got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (wif.wall_req && !qseen) begin
        qseen = 1'b1;
        qx    = wif.wall_tx;
        qy    = wif.wall_ty;
      end
      if (move_en) got = 1'b1;
      else @(negedge frame_clk);
    end
    chk("turn step seen", 32'(got), 32'd1);
    chk("turn query", {17'd0, qseen, qx, qy}, {17'd0, 1'b1, 7'd41, 7'd29});
    chk("turn dir", 32'(dir), 32'd0);
    chk("turn motion_y", 32'(motion_y), 32'h3FF);
    chk("turn motion_x", 32'(motion_x), 32'd0);
    chk("turn pend", 32'(pend_valid), 32'd0);

    // Reset while a query is outstanding; a late ack after release is ignored
    pos_x = 10'd320; pos_y = 10'd240; ack_on = 1'b0;
    do_reset();
    keycode = 8'h1A;
    @(negedge frame_clk);
    keycode = 8'h00;
    @(negedge frame_clk);
    chk("midq req before reset", 32'(wif.wall_req), 32'd1);
    chk("midq pend before reset", 32'(pend_valid), 32'd1);
    Reset = 1'b1;
    #1;
    chk("midq req drops", 32'(wif.wall_req), 32'd0);
    @(negedge frame_clk);
    Reset    = 1'b0;
    late_ack = 1'b1;
    @(negedge frame_clk);
    late_ack = 1'b0;
    chk("midq late ack req", 32'(wif.wall_req), 32'd0);
    chk("midq dir", 32'(dir), 32'd3);
    chk("midq pend", 32'(pend_valid), 32'd0);
    @(negedge frame_clk);
    chk("midq requery current", {24'd0, wif.wall_req, wif.wall_tx}, {24'd0, 1'b1, 7'd41});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
